heartbeat_rate_gen: RTL



---
 rtl/heartbeat_rate_gen.sv | 217 +++++++++++++++++++++
 1 files changed

// File: rtl/heartbeat_rate_gen.sv
`timescale 1ns / 1ps
// heartbeat_rate_gen
//
// Beat-rate generator feeding the heartbeat pattern stage. It synchronizes
// the board enable switch, turns two push-buttons into a saturating 4-bit rate
// setting (1..15, reset value 8) and emits a one-clock `step` strobe every
// 16*(16-rate)*BASE_DIV clocks while enabled.
//
// Optional feature macro: HEARTBEAT_RATE_DEBOUNCE_EN
//   defined   - each synchronized button is debounced for DB_CYCLES clocks.
//   undefined - the synchronized level is used directly; DB_CYCLES is ignored.
//
// Parameters:
//   BASE_DIV   clocks per base tick
//   DB_CYCLES  clocks a button level must stay stable before it is accepted
//
// Ports:
//   clk      in   system clock
//   reset    in   asynchronous active-low reset
//   en       in   raw enable switch (asynchronous)
//   btn_up   in   raw rate-up button (asynchronous, bouncy)
//   btn_dn   in   raw rate-down button (asynchronous, bouncy)
//   step     out  one-clock strobe advancing the heartbeat pattern
//   rate     out  current rate setting, 1..15
//   en_sync  out  synchronized enable for the downstream heartbeat stage

module heartbeat_rate_gen #(
    parameter int unsigned BASE_DIV  = 1_000_000,
    parameter int unsigned DB_CYCLES = 2_000_000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       en,
    input  logic       btn_up,
    input  logic       btn_dn,
    output logic       step,
    output logic [3:0] rate,
    output logic       en_sync
);

    localparam int unsigned PreW = (BASE_DIV > 1) ? $clog2(BASE_DIV) : 1;
    localparam logic [PreW-1:0] PreMax = PreW'(BASE_DIV - 1);

    // ------------------------------------------------------------------
    // Two-flop synchronizers
    // ------------------------------------------------------------------
    logic en_s1_q, en_s2_q;
    logic up_s1_q, up_s2_q;
    logic dn_s1_q, dn_s2_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            en_s1_q <= 1'b0;
            en_s2_q <= 1'b0;
            up_s1_q <= 1'b0;
            up_s2_q <= 1'b0;
            dn_s1_q <= 1'b0;
            dn_s2_q <= 1'b0;
        end else begin
            en_s1_q <= en;
            en_s2_q <= en_s1_q;
            up_s1_q <= btn_up;
            up_s2_q <= up_s1_q;
            dn_s1_q <= btn_dn;
            dn_s2_q <= dn_s1_q;
        end
    end

    assign en_sync = en_s2_q;

    // ------------------------------------------------------------------
    // Accepted button levels
    // ------------------------------------------------------------------
    logic up_acc, dn_acc;

`ifdef HEARTBEAT_RATE_DEBOUNCE_EN
    localparam int unsigned DbW = (DB_CYCLES > 1) ? $clog2(DB_CYCLES) : 1;
    localparam logic [DbW-1:0] DbMax = DbW'(DB_CYCLES - 1);

    logic [DbW-1:0] up_cnt_q, up_cnt_d, dn_cnt_q, dn_cnt_d;
    logic           up_acc_q, up_acc_d, dn_acc_q, dn_acc_d;

    // A counter only runs while the synchronized level disagrees with the
    // accepted one; any return to the accepted level restarts the wait.
    always_comb begin
        up_cnt_d = up_cnt_q;
        up_acc_d = up_acc_q;
        dn_cnt_d = dn_cnt_q;
        dn_acc_d = dn_acc_q;

        if (up_s2_q == up_acc_q) begin
            up_cnt_d = '0;
        end else if (up_cnt_q == DbMax) begin
            up_cnt_d = '0;
            up_acc_d = up_s2_q;
        end else begin
            up_cnt_d = up_cnt_q + 1'b1;
        end

        if (dn_s2_q == dn_acc_q) begin
            dn_cnt_d = '0;
        end else if (dn_cnt_q == DbMax) begin
            dn_cnt_d = '0;
            dn_acc_d = dn_s2_q;
        end else begin
            dn_cnt_d = dn_cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_cnt_q <= '0;
            up_acc_q <= 1'b0;
            dn_cnt_q <= '0;
            dn_acc_q <= 1'b0;
        end else begin
            up_cnt_q <= up_cnt_d;
            up_acc_q <= up_acc_d;
            dn_cnt_q <= dn_cnt_d;
            dn_acc_q <= dn_acc_d;
        end
    end

    assign up_acc = up_acc_q;
    assign dn_acc = dn_acc_q;
`else
    logic unused_db_cycles;
    assign unused_db_cycles = ^DB_CYCLES;

    assign up_acc = up_s2_q;
    assign dn_acc = dn_s2_q;
`endif

    // ------------------------------------------------------------------
    // Press events and rate register
    // ------------------------------------------------------------------
    logic       up_prev_q, dn_prev_q;
    logic       up_ev, dn_ev;
    logic [3:0] rate_q, rate_d;

    assign up_ev = up_acc & ~up_prev_q;
    assign dn_ev = dn_acc & ~dn_prev_q;

    always_comb begin
        rate_d = rate_q;
        if (up_ev && !dn_ev && rate_q != 4'd15) begin
            rate_d = rate_q + 4'd1;
        end else if (dn_ev && !up_ev && rate_q != 4'd1) begin
            rate_d = rate_q - 4'd1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            up_prev_q <= 1'b0;
            dn_prev_q <= 1'b0;
            rate_q    <= 4'd8;
        end else begin
            up_prev_q <= up_acc;
            dn_prev_q <= dn_acc;
            rate_q    <= rate_d;
        end
    end

    assign rate = rate_q;

    // ------------------------------------------------------------------
    // Prescaler and step counter
    // ------------------------------------------------------------------
    logic [PreW-1:0] pre_q, pre_d;
    logic [7:0]      scnt_q, scnt_d;
    logic            step_q, step_d;
    logic [3:0]      period_hi;
    logic [7:0]      period_m1;

    // 16 - rate wraps correctly in 4 bits for rate 1..15, so the period is
    // simply that value shifted up by four.
    assign period_hi = 4'd0 - rate_q;
    assign period_m1 = {period_hi, 4'b0000} - 8'd1;

    always_comb begin
        pre_d  = pre_q;
        scnt_d = scnt_q;
        step_d = 1'b0;

        if (!en_s2_q) begin
            pre_d  = '0;
            scnt_d = '0;
        end else if (pre_q == PreMax) begin
            pre_d = '0;
            // >= rather than == so a rate raised mid-period fires promptly.
            if (scnt_q >= period_m1) begin
                scnt_d = '0;
                step_d = 1'b1;
            end else begin
                scnt_d = scnt_q + 8'd1;
            end
        end else begin
            pre_d = pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pre_q  <= '0;
            scnt_q <= '0;
            step_q <= 1'b0;
        end else begin
            pre_q  <= pre_d;
            scnt_q <= scnt_d;
            step_q <= step_d;
        end
    end

    assign step = step_q;

endmodule
